regfile_dump_reader: RTL and testbench
======================================

# regfile_dump_reader

Sequential read-out engine for the 32x64 register file: on a start command it walks the register file read port through a programmed address range and streams each 64-bit register value, tagged with its address, out over a valid/ready interface. It is the read-side counterpart to the register file's write path. Uses: debug dumps, state snapshots for the test harness, and bulk transfer to a downstream consumer. It drives one read-address port (SA) and consumes the matching read-data bus (A). The other port (SB/B) and the write port remain free for the datapath.

## Interface
- DATA_WIDTH, 64, register width / out_data width
- ADDR_WIDTH, 5, register address width
- MAX_REG, 30, highest dumpable register; register 31 is the hard-wired zero register and is never dumped
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately
- start  in  1  command pulse; sampled only in IDLE
- first  in  ADDR_WIDTH  first register of range; sampled with start
- last  in  ADDR_WIDTH  last register of range, inclusive; sampled with start
- abort  in  1  cancels a dump in progress; synchronous
- SA  out  ADDR_WIDTH  register file read address
- A  in  DATA_WIDTH  register file read data; combinational from SA
- out_data  out  DATA_WIDTH  captured register value
- out_addr  out  ADDR_WIDTH  address of out_data
- out_valid  out  1  out_data/out_addr/out_last valid
- out_ready  in  1  consumer accepts when out_valid && out_ready at a rising edge
- out_last  out  1  current word is register `last`
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, FETCH, SEND, DONE. Reset puts the block in IDLE and sets SA, out_data, out_addr, out_valid, out_last, busy, done, and err to 0.
- **IDLE:** SA=0.
  - start with first<=last and last<=MAX_REG: latch ptr=first, last_q=last, then go to FETCH.
  - start with an invalid range: err=1 for one cycle and stay in IDLE.
- **FETCH:** SA=ptr. At the edge, capture A into out_data, ptr into out_addr, and (ptr==last_q) into out_last. Set out_valid=1 and go to SEND.
- **SEND:** SA holds ptr. out_data, out_addr, and out_last are stable while out_valid && !out_ready.
  - On acceptance with out_last=0: ptr=ptr+1, out_valid=0, go to FETCH.
  - On acceptance with out_last=1: out_valid=0, go to DONE.
- **DONE:** done=1 for exactly this cycle, then go to IDLE.
- **abort:** in FETCH or SEND, the next edge forces IDLE, out_valid=0, out_last=0, and no done pulse. abort in IDLE or DONE is ignored (DONE completes normally).
- start while busy is ignored; there is no err and the range is not relatched.
- ptr never exceeds MAX_REG, so there is no wrap-around. Address arithmetic is ADDR_WIDTH bits unsigned.
- Data is captured at the FETCH edge. A register-file write to the same address on that same edge yields the pre-write value, because the register file's write lands at that edge. Later writes do not alter a word already captured.

## Timing
- start sampled at edge k: busy=1 and SA=first in cycle k..k+1. out_valid rises after edge k+1.
- Read-to-valid latency is 1 cycle. Throughput is at most 1 word per 2 cycles.
- With out_ready held high, an n-word dump accepts words at edges k+2, k+4, ..., k+2n.
- done is high between edges k+2n and k+2n+1. busy falls after edge k+2n+1.
- Backpressure of m cycles on a word delays all later events by m cycles.
- reset asserted mid-dump clears outputs asynchronously with no done. After reset is released, the first start is honoured.

## Test plan
- **Full dump:** preload R0..R30 with 64'h100+i, then start first=0, last=30 with out_ready=1. Expect 31 words, out_data=64'h100+i, out_addr=i, out_last only at addr 30, done after edge k+62.
- **Backpressure:** range 3..5, out_ready low for 4 cycles on word 4. Expect out_data=64'h104 and out_addr=4 held stable, no skipped or duplicated words, done 4 cycles later than the no-stall case.
- **Invalid ranges:** first=5,last=3 and first=0,last=31 each give err for 1 cycle, busy=0, and out_valid never rises.
- **Single register:** first=last=7 gives one word 64'h107 with out_last=1 and done after edge k+2.
- **Abort:** abort during the third word of range 0..10. Expect out_valid low after the next edge, no done, and a subsequent start 2..2 completing normally.
- **Async reset:** assert reset mid-dump between edges. All outputs go to 0 immediately, then a dump after reset is correct.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks the register file read port (SA/A) over a
// programmed inclusive address range and streams each register value,
// tagged with its address, out over a valid/ready interface.
module regfile_dump_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned MAX_REG    = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first,
    input  logic [ADDR_WIDTH-1:0] last,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] SA,
    input  logic [DATA_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] ptr, ptr_n;
    logic [ADDR_WIDTH-1:0] last_q, last_n;
    logic [ADDR_WIDTH-1:0] sa_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  valid_n;
    logic                  olast_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  err_n;
    logic                  range_ok;

    // Range is legal only if ordered and it stays clear of the zero register.
    always_comb begin
        range_ok = (first <= last) && (last <= ADDR_WIDTH'(MAX_REG));
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        last_n  = last_q;
        sa_n    = SA;
        data_n  = out_data;
        addr_n  = out_addr;
        valid_n = out_valid;
        olast_n = out_last;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state)
            IDLE: begin
                sa_n = '0;
                if (start) begin
                    if (range_ok) begin
                        ptr_n   = first;
                        last_n  = last;
                        sa_n    = first;
                        state_n = FETCH;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    olast_n = 1'b0;
                    sa_n    = '0;
                end else begin
                    // A is combinational from SA, which equals ptr here.
                    data_n  = A;
                    addr_n  = ptr;
                    olast_n = (ptr == last_q);
                    valid_n = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    olast_n = 1'b0;
                    sa_n    = '0;
                end else if (out_valid && out_ready) begin
                    valid_n = 1'b0;
                    if (out_last) begin
                        olast_n = 1'b0;
                        done_n  = 1'b1;
                        sa_n    = '0;
                        state_n = DONE;
                    end else begin
                        ptr_n   = ADDR_WIDTH'(ptr + 1'b1);
                        sa_n    = ADDR_WIDTH'(ptr + 1'b1);
                        state_n = FETCH;
                    end
                end
            end
            DONE: begin
                sa_n    = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
                olast_n = 1'b0;
                sa_n    = '0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            last_q    <= '0;
            SA        <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            last_q    <= last_n;
            SA        <= sa_n;
            out_data  <= data_n;
            out_addr  <= addr_n;
            out_valid <= valid_n;
            out_last  <= olast_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file.
module tb_regfile_dump_reader;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] first = '0;
    logic [AW-1:0] last = '0;
    logic [AW-1:0] SA;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] A;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          err;

    logic [DW-1:0] rf [32];

    int n_checks = 0;
    int n_pass   = 0;

    regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_REG(30)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .first     (first),
        .last      (last),
        .abort     (abort),
        .SA        (SA),
        .A         (A),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    assign A = rf[SA];

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Run one dump; exp_done is the edge offset (from the start edge) of done.
    task automatic dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                        input logic [AW-1:0] stall_addr, input int stall_n,
                        input int exp_done);
        int            left;
        int            words;
        bit            fin;
        logic [AW-1:0] exp_addr;
        left = stall_n; words = 0; fin = 0; exp_addr = f;
        first = f; last = l; start = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        for (int c = 0; c < 200 && !fin; c++) begin
            @(negedge clock);
            start = 1'b0; first = '0; last = '0;
            out_ready = 1'b1;
            if (out_valid && out_addr == stall_addr && left > 0) begin
                out_ready = 1'b0;
                left--;
                start = 1'b1;   // must be ignored while busy
            end
            check("err_quiet", err, 0);
            if (done) begin
                check("done_cycle", c, exp_done);
                check("word_count", words, int'(l) - int'(f) + 1);
                check("valid_in_done", out_valid, 0);
                fin = 1;
            end else begin
                check("busy", busy, 1);
                check("sa", SA, exp_addr);
                if (c == 0) check("valid_c0", out_valid, 0);
                if (out_valid) begin
                    check("out_addr", out_addr, exp_addr);
                    check("out_data", out_data, 64'h100 + exp_addr);
                    check("out_last", out_last, exp_addr == l);
                    if (out_ready) begin
                        words++;
                        exp_addr++;
                    end
                end
            end
        end
        if (!fin) check("done_timeout", 0, 1);
        start = 1'b0; first = '0; last = '0;
        @(negedge clock);
        check("done_pulse_end", done, 0);
        check("busy_after", busy, 0);
    endtask

    task automatic bad(input logic [AW-1:0] f, input logic [AW-1:0] l);
        first = f; last = l; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("bad_err", err, 1);
        check("bad_busy", busy, 0);
        check("bad_valid", out_valid, 0);
        check("bad_sa", SA, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bad_err_off", err, 0);
            check("bad_busy_off", busy, 0);
            check("bad_valid_off", out_valid, 0);
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 31; i++) rf[i] = 64'h100 + 64'(i);
        rf[31] = '0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        check("rst_sa", SA, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Full dump, single register, backpressure
        dump(5'd0, 5'd30, 5'd31, 0, 62);
        dump(5'd7, 5'd7, 5'd31, 0, 2);
        dump(5'd3, 5'd5, 5'd4, 4, 10);

        // Invalid ranges
        bad(5'd5, 5'd3);
        bad(5'd0, 5'd31);

        // Abort during the third word of 0..10
        first = 5'd0; last = 5'd10; start = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (out_valid && out_addr == 5'd2) found = 1;
        end
        check("abort_reached", found, 1);
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        abort = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_last", out_last, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("abort_no_done", done, 0);
            check("abort_no_valid", out_valid, 0);
        end
        dump(5'd2, 5'd2, 5'd31, 0, 2);

        // Asynchronous reset mid-dump
        first = 5'd0; last = 5'd30; start = 1'b1; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_sa", SA, 0);
        check("arst_data", out_data, 0);
        check("arst_addr", out_addr, 0);
        check("arst_valid", out_valid, 0);
        check("arst_last", out_last, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        dump(5'd4, 5'd6, 5'd31, 0, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
